// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle LSL/LSR/ASR/pass shifter that moves STEP bit positions per cycle.
// Latency: 1 cycle for pass or amt=0, otherwise 1+ceil(amt/STEP) cycles from accept to out_valid.
// Backpressure: holds the result in DONE until out_ready; in_ready only in IDLE. Optional macro SEQ_SHIFTER_CARRY_EN adds cout.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AW-1:0]    amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic             cout
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_LSL  = 2'b01;
  localparam logic [1:0] MODE_LSR  = 2'b10;
  localparam logic [1:0] MODE_ASR  = 2'b11;

  // One extra bit so STEP=WIDTH and the saturation bound are representable.
  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW:0]      k;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH-1:0] asr_val;
`ifdef SEQ_SHIFTER_CARRY_EN
  logic             cout_q, cout_d;
`endif

  // Per-cycle step k = min(STEP, rem); the extra bit on each side of the
  // shifted value captures the last bit shifted out (carry).
  always_comb begin
    k       = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
    lsl_ext = {1'b0, sout_q} << k;
    lsr_ext = {sout_q, 1'b0} >> k;
    asr_val = $signed(sout_q) >>> k;
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
`ifdef SEQ_SHIFTER_CARRY_EN
    cout_d  = cout_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sout_d = in;
          mode_d = shift;
          // Only reachable for non-power-of-two WIDTH: clamp so the
          // iteration saturates instead of wrapping.
          rem_d  = ({1'b0, amt} >= WIDTH_W) ? WIDTH_W[AW-1:0] : amt;
`ifdef SEQ_SHIFTER_CARRY_EN
          cout_d = 1'b0;
`endif
          state_d = (shift == MODE_PASS || amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        rem_d = rem_q - k[AW-1:0];
        case (mode_q)
          MODE_LSL: begin
            sout_d = lsl_ext[WIDTH-1:0];
`ifdef SEQ_SHIFTER_CARRY_EN
            cout_d = lsl_ext[WIDTH];
`endif
          end
          MODE_LSR: begin
            sout_d = lsr_ext[WIDTH:1];
`ifdef SEQ_SHIFTER_CARRY_EN
            cout_d = lsr_ext[0];
`endif
          end
          MODE_ASR: begin
            sout_d = asr_val;
`ifdef SEQ_SHIFTER_CARRY_EN
            cout_d = lsr_ext[0];
`endif
          end
          default: ;
        endcase
        if ({1'b0, rem_q} <= STEP_W) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sout_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_PASS;
`ifdef SEQ_SHIFTER_CARRY_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
`ifdef SEQ_SHIFTER_CARRY_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sout      = sout_q;
`ifdef SEQ_SHIFTER_CARRY_EN
  assign cout      = cout_q;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4, WIDTH=16) driven with
// directed and random commands, results checked against a whole-shift reference model.
module tb_seq_shifter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [15:0] din      [2];
  logic [15:0] sout     [2];
  logic [1:0]  shift    [2];
  logic [3:0]  amt      [2];
`ifdef SEQ_SHIFTER_CARRY_EN
  logic        cout     [2];
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] a_data[2];
  logic [1:0]  a_mode[2];
  int          a_amt [2];

  seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
`ifdef SEQ_SHIFTER_CARRY_EN
    .cout(cout[0]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in(din[0]), .shift(shift[0]), .amt(amt[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sout(sout[0]));

  seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
`ifdef SEQ_SHIFTER_CARRY_EN
    .cout(cout[1]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in(din[1]), .shift(shift[1]), .amt(amt[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sout(sout[1]));

  // Reference model: the whole shift applied at once.
  function automatic logic [15:0] ref_res(input logic [15:0] d, input logic [1:0] m, input int a);
    logic signed [15:0] sd;
    sd = d;
    case (m)
      2'b00:   return d;
      2'b01:   return d << a;
      2'b10:   return d >> a;
      default: return 16'(sd >>> a);
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] m, input int a, input int step);
    if (m == 2'b00 || a == 0) return 1;
    return 1 + (a + step - 1) / step;
  endfunction

  function automatic logic ref_cout(input logic [15:0] d, input logic [1:0] m, input int a);
    if (m == 2'b00 || a == 0) return 1'b0;
    if (m == 2'b01) return d[16 - a];
    return d[a - 1];
  endfunction

  task automatic start_cmd(input int id, input logic [15:0] d, input logic [1:0] m, input int a);
    @(negedge clk);
    vectors++;
    if (in_ready[id] !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_in_ready dut%0d: got %b want 1", id, in_ready[id]);
    end
    in_valid[id] = 1'b1;
    din[id] = d;
    shift[id] = m;
    amt[id] = 4'(a);
    a_data[id] = d;
    a_mode[id] = m;
    a_amt[id] = a;
    @(posedge clk);
    #1;
    in_valid[id] = 1'b0;
    din[id] = 16'($urandom);
    shift[id] = 2'($urandom);
    amt[id] = 4'($urandom);
  endtask

  task automatic finish_cmd(input int id, input int stall, input int exp_const);
    int cnt;
    bit got;
    logic [15:0] exp_s;
    int exp_l;
    cnt = 0;
    got = 0;
    exp_s = ref_res(a_data[id], a_mode[id], a_amt[id]);
    exp_l = ref_lat(a_mode[id], a_amt[id], (id == 0) ? 1 : 4);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      cnt++;
      if (out_valid[id] === 1'b1) got = 1;
      else begin
        // Busy: inputs and out_ready must have no effect.
        in_valid[id] = 1'($urandom);
        din[id] = 16'($urandom);
        shift[id] = 2'($urandom);
        amt[id] = 4'($urandom);
        out_ready[id] = 1'($urandom);
      end
    end
    in_valid[id] = 1'b0;
    out_ready[id] = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL timeout dut%0d: out_valid never rose, want latency %0d", id, exp_l);
      return;
    end
    if (cnt != exp_l) begin
      miscompares++;
      $display("FAIL latency dut%0d: got %0d want %0d", id, cnt, exp_l);
    end
    vectors++;
    if (sout[id] !== exp_s) begin
      miscompares++;
      $display("FAIL sout dut%0d mode=%0d amt=%0d in=%h: got %h want %h",
               id, a_mode[id], a_amt[id], a_data[id], sout[id], exp_s);
    end
    if (exp_const >= 0) begin
      vectors++;
      if (sout[id] !== 16'(exp_const)) begin
        miscompares++;
        $display("FAIL sout_directed dut%0d: got %h want %h", id, sout[id], 16'(exp_const));
      end
    end
`ifdef SEQ_SHIFTER_CARRY_EN
    vectors++;
    if (cout[id] !== ref_cout(a_data[id], a_mode[id], a_amt[id])) begin
      miscompares++;
      $display("FAIL cout dut%0d: got %b want %b", id, cout[id],
               ref_cout(a_data[id], a_mode[id], a_amt[id]));
    end
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid[id] = 1'($urandom);
      din[id] = 16'($urandom);
      @(negedge clk);
      vectors++;
      if (out_valid[id] !== 1'b1 || in_ready[id] !== 1'b0 || sout[id] !== exp_s) begin
        miscompares++;
        $display("FAIL stall dut%0d: out_valid=%b in_ready=%b sout=%h want 1 0 %h",
                 id, out_valid[id], in_ready[id], sout[id], exp_s);
      end
    end
    in_valid[id] = 1'b0;
    out_ready[id] = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready[id] !== 1'b1 || out_valid[id] !== 1'b0) begin
      miscompares++;
      $display("FAIL release dut%0d: in_ready=%b out_valid=%b want 1 0", id, in_ready[id], out_valid[id]);
    end
    out_ready[id] = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int id = 0; id < 2; id++) begin
      vectors++;
      if (in_ready[id] !== 1'b1 || out_valid[id] !== 1'b0 || sout[id] !== 16'h0000) begin
        miscompares++;
        $display("FAIL %s dut%0d: in_ready=%b out_valid=%b sout=%h want 1 0 0000",
                 tag, id, in_ready[id], out_valid[id], sout[id]);
      end
`ifdef SEQ_SHIFTER_CARRY_EN
      vectors++;
      if (cout[id] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_cout dut%0d: got %b want 0", tag, id, cout[id]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int id = 0; id < 2; id++) begin
      in_valid[id] = 1'b0;
      out_ready[id] = 1'b0;
      din[id] = 16'h0;
      shift[id] = 2'b00;
      amt[id] = 4'h0;
    end
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_step1();
    start_cmd(0, 16'h8001, 2'b01, 1);  finish_cmd(0, 0, 16'h0002);
    start_cmd(0, 16'h8000, 2'b11, 15); finish_cmd(0, 0, 16'hFFFF);
    start_cmd(0, 16'h8000, 2'b10, 15); finish_cmd(0, 0, 16'h0001);
  endtask

  task automatic test_step4();
    start_cmd(1, 16'h8000, 2'b10, 6); finish_cmd(1, 0, 16'h0200);
    start_cmd(1, 16'h8000, 2'b11, 6); finish_cmd(1, 0, 16'hFE00);
  endtask

  task automatic test_pass_zero();
    for (int id = 0; id < 2; id++) begin
      start_cmd(id, 16'h1234, 2'b00, 7); finish_cmd(id, 0, 16'h1234);
      start_cmd(id, 16'hA5C3, 2'b01, 0); finish_cmd(id, 0, 16'hA5C3);
    end
  endtask

  task automatic test_backpressure();
    start_cmd(0, 16'h00F0, 2'b01, 2); finish_cmd(0, 3, 16'h03C0);
    start_cmd(1, 16'hF00F, 2'b11, 5); finish_cmd(1, 3, 16'hFF80);
  endtask

  task automatic test_reset_mid_shift();
    start_cmd(0, 16'h0F0F, 2'b01, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("mid_shift_reset");
    rst_n = 1'b1;
    start_cmd(0, 16'h0001, 2'b01, 3); finish_cmd(0, 0, 16'h0008);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int id;
      id = n % 2;
      start_cmd(id, 16'($urandom), 2'($urandom), int'($urandom_range(0, 15)));
      finish_cmd(id, int'($urandom_range(0, 2)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_step1();
    test_step4();
    test_pass_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
